// File: rtl/mu0_serial_alu.sv
// MU0 serial ALU: computes B, B+1, A+B or A-B one DIGIT-bit slice per clock,
// LSB slice first, then publishes the result with zero/neg/carry/ovf flags
// and a one-cycle done pulse. Latency is WIDTH/DIGIT clocks from start.
module mu0_serial_alu #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       alufs,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("mu0_serial_alu: need WIDTH>=2, DIGIT>=1 and WIDTH divisible by DIGIT");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] res_sr;

  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] res_next;
  logic             cin_msb;
  logic             last;

  assign busy = (state == RUN);

  // Slice adder: current low slices of X and Y plus the running carry, and the
  // result register as it will look once this slice is shifted in at the top.
  always_comb begin
    slice_sum = {1'b0, x_sr[DIGIT-1:0]} + {1'b0, y_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy};
    res_next  = (res_sr >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // On the final slice bit DIGIT-1 is the word MSB; its carry-in is recovered
    // from the sum bit since s = x ^ y ^ cin.
    cin_msb   = slice_sum[DIGIT-1] ^ x_sr[DIGIT-1] ^ y_sr[DIGIT-1];
    last      = (cnt == CW'(N - 1));
  end

  // Control: IDLE/RUN sequencing, slice counter, carry register and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cy    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          cnt   <= '0;
          cy    <= alufs[0];
        end
      end else begin
        cy  <= slice_sum[DIGIT];
        cnt <= cnt + CW'(1);
        if (last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  // Operand shift registers: X/Y are formed once at start, so later changes on
  // a, b or alufs cannot disturb the operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sr   <= '0;
      y_sr   <= '0;
      res_sr <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        x_sr   <= alufs[1] ? a : '0;
        y_sr   <= (alufs == 2'b11) ? ~b : b;
        res_sr <= '0;
      end
    end else begin
      x_sr   <= x_sr >> DIGIT;
      y_sr   <= y_sr >> DIGIT;
      res_sr <= res_next;
    end
  end

  // Published result and flags: updated together on the last slice only, held
  // otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu   <= '0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN && last) begin
      alu   <= res_next;
      zero  <= (res_next == '0);
      neg   <= res_next[WIDTH-1];
      carry <= slice_sum[DIGIT];
      ovf   <= cin_msb ^ slice_sum[DIGIT];
    end
  end

endmodule

// File: doc/mu0_serial_alu.md
MU0_SERIAL_ALU -- requirements
Module: mu0_serial_alu

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width in bits.
REQ-002 Parameter DIGIT, default 4, sets the number of bits processed per clock cycle.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  is the reset: asynchronous, active-high.
REQ-005 Port start  input  1  is the operation request, sampled only in IDLE.
REQ-006 Port alufs  input  2  selects the function: 00=B, 01=B+1, 10=A+B, 11=A-B.
REQ-007 Port a  input  WIDTH  is operand A.
REQ-008 Port b  input  WIDTH  is operand B.
REQ-009 Port busy  output  1  is high while an operation is in progress.
REQ-010 Port done  output  1  is a one-cycle pulse marking a new valid result.
REQ-011 Port alu  output  WIDTH  is the registered result.
REQ-012 Ports zero, neg, carry, ovf  output  1 each  are registered result flags.

Function
REQ-013 Elaboration SHALL fail unless WIDTH>=2, DIGIT>=1 and WIDTH%DIGIT==0; N = WIDTH/DIGIT.
REQ-014 Each operation SHALL compute X + Y + c0: X = A if alufs[1] else 0; Y = ~B if alufs==11 else B; c0 = alufs[0].
REQ-015 The FSM SHALL have two states, IDLE and RUN.
REQ-016 In IDLE, start=1 at an edge (E0) SHALL latch a, b and alufs, clear the digit counter, load the carry register with c0, and enter RUN.
REQ-017 In RUN, edges E1..EN SHALL each add one DIGIT-bit slice, LSB slice first, using the carry register, and shift the slice sum into the result shift register.
REQ-018 At edge EN, the block SHALL update alu and all four flags together, pulse done high for exactly one cycle, and return to IDLE.
REQ-019 busy SHALL be high from after E0 through EN, and low otherwise; busy and done are never high together.
REQ-020 Latency SHALL be N cycles from the start-sampling edge to done; DIGIT=WIDTH gives a latency of 1.
REQ-021 start while busy=1 SHALL be ignored and SHALL NOT affect the latched operands.
REQ-022 start high in the same cycle as done SHALL be accepted, allowing back-to-back operations with one result every N+1 cycles.
REQ-023 Changes on a, b or alufs after E0 SHALL NOT affect the operation in flight.
REQ-024 alu and the flags SHALL hold their values until the next EN edge, and SHALL NOT change on start.
REQ-025 The result SHALL be truncated modulo 2^WIDTH.
REQ-026 carry SHALL be the carry out of bit WIDTH-1; for A-B, carry=1 means no borrow.
REQ-027 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB; it is computed for all modes.
REQ-028 neg SHALL equal alu[WIDTH-1].
REQ-029 zero SHALL be 1 when alu equals 0.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, busy=0, done=0, alu=0, zero=0, neg=0, carry=0 and ovf=0, and clear the counter and internal registers.
REQ-031 Reset asserted mid-operation SHALL abort the operation; no done pulse follows for the aborted operation.
REQ-032 After reset deasserts, the first rising edge with start=1 SHALL begin a new operation.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-033 alufs=10, a=0x1234, b=0x1111, one-cycle start -> done exactly 4 cycles later, alu=0x2345, zero=neg=carry=ovf=0, busy high for 4 cycles.
REQ-034 alufs=11, a=0x0005, b=0x0005 -> alu=0x0000, zero=1, carry=1, neg=0, ovf=0.
REQ-035 alufs=11, a=0x8000, b=0x0001 -> alu=0x7FFF, ovf=1, carry=1, neg=0.
REQ-036 Two modes back-to-back:
- alufs=01, b=0xFFFF -> alu=0x0000, zero=1, carry=1, ovf=0.
- Then, with start high during that done cycle, alufs=00, b=0x8000 -> alu=0x8000, neg=1, done 5 cycles after the first done.
REQ-037 Abort and ignored start:
- Start A+B; pulse start again with new operands after 1 cycle -> ignored, original result returned.
- Start another operation and assert reset after 2 cycles -> alu=0, busy=0, no done pulse.
REQ-038 Instance WIDTH=8, DIGIT=8: alufs=10, a=0x7F, b=0x01 -> done 1 cycle after start, alu=0x80, neg=1, ovf=1, carry=0.
